alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning (each SHALL be >= 1):
- ADD_CYCLES, 1, settle cycles for Op 00/01 (Add/Sub).
- MUL_CYCLES, 2, settle cycles for Op 10 (Mul).
- DIV_CYCLES, 4, settle cycles for Op 11 (Div).
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning:
- Clk  input  1  single clock; all state updates on rising edge.
- Rst  input  1  asynchronous, active-high reset.
- InValid  input  1  upstream command valid.
- InReady  output  1  block can accept a command.
- InA  input  32  IEEE-754 single operand A.
- InB  input  32  IEEE-754 single operand B.
- InOp  input  2  00 Add, 01 Sub, 10 Mul, 11 Div.
- AluA  output  32  operand A to the combinational FP ALU.
- AluB  output  32  operand B to the combinational FP ALU.
- AluOp  output  2  opcode to the combinational FP ALU.
- AluOut  input  32  combinational FP ALU result.
- OutValid  output  1  result valid.
- OutReady  input  1  downstream accepts result.
- Out  output  32  captured result.
- OutFlags  output  4  {NaN, Inf, Zero, Denorm} of Out.
- OpCount  output  16  completed-result counter.

Function
REQ-003 FSM SHALL have three states: IDLE, EXEC, DONE.
REQ-004 InReady SHALL be 1 only in IDLE; a command is accepted on an edge where InValid=1 and InReady=1.
REQ-005 On acceptance, InA/InB/InOp SHALL be registered, Cnt SHALL load L-1 (L = latency selected by InOp per REQ-001), state -> EXEC.
REQ-006 AluA/AluB/AluOp SHALL be driven only from the operand registers and held stable through EXEC and DONE.
REQ-007 In EXEC, each edge: if Cnt=0, AluOut SHALL be captured into Out, OutFlags computed from AluOut and registered, state -> DONE; else Cnt decrements.
REQ-008 OutValid SHALL rise exactly L rising edges after the acceptance edge and SHALL equal 1 only in DONE.
REQ-009 In DONE, Out and OutFlags SHALL remain stable until the edge where OutReady=1; on that edge state -> IDLE, OutValid -> 0, OpCount increments.
REQ-010 OpCount SHALL wrap 0xFFFF -> 0x0000 without side effects.
REQ-011 No new command SHALL be accepted in the same cycle a result is consumed; the earliest next acceptance is the edge after return to IDLE. Back-to-back throughput is therefore one result per L+2 cycles.
REQ-012 Flags SHALL be classified from bits [30:23] (exponent E) and [22:0] (mantissa M):
- NaN = E=0xFF, M!=0.
- Inf = E=0xFF, M=0.
- Zero = E=0, M=0.
- Denorm = E=0, M!=0.
- Flags are sign-independent; at most one flag is set.
REQ-013 InValid and operand changes during EXEC/DONE SHALL be ignored.
REQ-014 Cnt width SHALL fit the largest latency parameter.

Reset
REQ-015 Rst=1 SHALL asynchronously force:
- state IDLE, InReady=1, OutValid=0.
- Out, OutFlags, OpCount, Cnt, AluA, AluB, AluOp all 0.
REQ-016 Reset during EXEC or DONE SHALL discard the in-flight operation without incrementing OpCount; the first command after Rst deasserts SHALL follow REQ-004..REQ-009 normally.

Verification
REQ-017 Bench SHALL stub AluOut with a reference FP model and cover these directed scenarios:
- Add 0x3F800000 + 0x40000000, OutReady=1 -> OutValid 1 edge after accept, Out=0x40400000, OutFlags=0000, OpCount=1.
- Mul 0x40000000 * 0x40400000 -> OutValid exactly 2 edges after accept, Out=0x40C00000; Div with stub AluOut=0x7F800000 -> OutValid after 4 edges, OutFlags=0100.
- Result held with OutReady=0 for 5 cycles -> Out/OutFlags stable, InReady=0, InValid pulses ignored; OutReady=1 -> IDLE next edge, OpCount+1.
- Rst asserted 2 cycles into Div EXEC -> immediate OutValid=0, InReady=1, Out=0, OpCount unchanged at 0; next Add completes normally.
- Stub AluOut = 0x7FC00000 / 0x00000000 / 0x80000001 -> OutFlags 1000 / 0010 / 0001.
- 65536 consumed results -> OpCount wraps to 0x0000.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue/hold controller in front of a combinational FP ALU: accepts one command,
// waits an opcode-dependent settle time, captures and classifies the result.
module alu_issue_ctrl #(
    parameter int ADD_CYCLES = 1,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        InValid,
    output logic        InReady,
    input  logic [31:0] InA,
    input  logic [31:0] InB,
    input  logic [1:0]  InOp,
    output logic [31:0] AluA,
    output logic [31:0] AluB,
    output logic [1:0]  AluOp,
    input  logic [31:0] AluOut,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] Out,
    output logic [3:0]  OutFlags,
    output logic [15:0] OpCount
);

    localparam int MAX_AM  = (ADD_CYCLES > MUL_CYCLES) ? ADD_CYCLES : MUL_CYCLES;
    localparam int MAX_LAT = (MAX_AM > DIV_CYCLES) ? MAX_AM : DIV_CYCLES;
    // Counter holds L-1 at most, so clog2 of the largest latency is enough.
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [31:0]      out_q, out_d;
    logic [3:0]       flags_q, flags_d;
    logic [15:0]      op_count_q, op_count_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    function automatic logic [CNT_W-1:0] lat_m1(input logic [1:0] op);
        case (op)
            2'b10:   return CNT_W'(MUL_CYCLES - 1);
            2'b11:   return CNT_W'(DIV_CYCLES - 1);
            default: return CNT_W'(ADD_CYCLES - 1);
        endcase
    endfunction

    // {NaN, Inf, Zero, Denorm}; sign bit deliberately ignored.
    function automatic logic [3:0] classify(input logic [31:0] x);
        logic exp_ones;
        logic exp_zero;
        logic man_zero;
        exp_ones = (x[30:23] == 8'hFF);
        exp_zero = (x[30:23] == 8'h00);
        man_zero = (x[22:0] == 23'd0);
        return {exp_ones & ~man_zero, exp_ones & man_zero,
                exp_zero & man_zero, exp_zero & ~man_zero};
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        out_d       = out_q;
        flags_d     = flags_q;
        op_count_d  = op_count_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (InValid) begin
                    a_d        = InA;
                    b_d        = InB;
                    op_d       = InOp;
                    cnt_d      = lat_m1(InOp);
                    in_ready_d = 1'b0;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    out_d       = AluOut;
                    flags_d     = classify(AluOut);
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                // Going back to IDLE here (not straight to EXEC) means a command
                // can never be taken on the same edge a result is consumed.
                if (OutReady) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    op_count_d  = op_count_q + 16'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            out_q       <= '0;
            flags_q     <= '0;
            op_count_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            out_q       <= out_d;
            flags_q     <= flags_d;
            op_count_q  <= op_count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign InReady  = in_ready_q;
    assign OutValid = out_valid_q;
    assign AluA     = a_q;
    assign AluB     = b_q;
    assign AluOp    = op_q;
    assign Out      = out_q;
    assign OutFlags = flags_q;
    assign OpCount  = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: FP reference stub on AluOut, directed plus random ops.
module tb_alu_issue_ctrl;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [31:0] InA = '0;
    logic [31:0] InB = '0;
    logic [1:0]  InOp = '0;
    logic [31:0] AluA;
    logic [31:0] AluB;
    logic [1:0]  AluOp;
    logic [31:0] AluOut;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [31:0] Out;
    logic [3:0]  OutFlags;
    logic [15:0] OpCount;

    logic        stub_en = 1'b0;
    logic [31:0] stub_val = '0;
    int          tests = 0;
    int          fails = 0;
    int          model_count = 0;

    alu_issue_ctrl dut (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
        .InA(InA), .InB(InB), .InOp(InOp),
        .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluOut(AluOut),
        .OutValid(OutValid), .OutReady(OutReady), .Out(Out),
        .OutFlags(OutFlags), .OpCount(OpCount)
    );

    always #5 Clk = ~Clk;

    // Single-precision <-> double conversion; denormals flush, overflow goes to Inf.
    function automatic real sp2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'h00) return 0.0;
        d = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        int          e;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        if (e <= 0) return {d[63], 31'd0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] ref_fp(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
        real x;
        real y;
        x = sp2r(a);
        y = sp2r(b);
        case (op)
            2'b00:   return r2sp(x + y);
            2'b01:   return r2sp(x - y);
            2'b10:   return r2sp(x * y);
            default: return r2sp(x / y);
        endcase
    endfunction

    function automatic logic [3:0] ref_flags(input logic [31:0] x);
        int e;
        int m;
        e = int'(x[30:23]);
        m = int'(x[22:0]);
        return {(e == 255 && m != 0), (e == 255 && m == 0), (e == 0 && m == 0), (e == 0 && m != 0)};
    endfunction

    function automatic int ref_lat(input logic [1:0] op);
        if (op == 2'b10) return 2;
        if (op == 2'b11) return 4;
        return 1;
    endfunction

    assign AluOut = stub_en ? stub_val : ref_fp(AluA, AluB, AluOp);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_normal();
        logic [31:0] r;
        r = $urandom;
        return {r[31], 8'($urandom_range(110, 144)), r[22:0]};
    endfunction

    // Called at #1 after a rising edge with the DUT idle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          input int hold, input logic use_stub, input logic [31:0] stub);
        int          n;
        logic [31:0] exp_out;
        logic [3:0]  exp_fl;
        stub_en  = use_stub;
        stub_val = stub;
        InA = a; InB = b; InOp = op; InValid = 1'b1; OutReady = 1'b0;
        check("in_ready_idle", InReady, 1);
        exp_out = use_stub ? stub : ref_fp(a, b, op);
        exp_fl  = ref_flags(exp_out);
        @(posedge Clk); #1;
        InValid = 1'($urandom); InA = $urandom; InB = $urandom; InOp = 2'($urandom);
        check("in_ready_exec", InReady, 0);
        n = 0;
        while (!OutValid && n < 20) begin
            @(posedge Clk); #1;
            n++;
            InValid = 1'($urandom); InA = $urandom; InOp = 2'($urandom);
        end
        check("latency", n, ref_lat(op));
        check("alu_a", AluA, a);
        check("alu_b", AluB, b);
        check("alu_op", AluOp, op);
        check("out", Out, exp_out);
        check("flags", OutFlags, exp_fl);
        check("in_ready_done", InReady, 0);
        for (int i = 0; i < hold; i++) begin
            stub_en = 1'b1; stub_val = $urandom;
            @(posedge Clk); #1;
            check("hold_valid", OutValid, 1);
            check("hold_out", Out, exp_out);
            check("hold_flags", OutFlags, exp_fl);
            check("hold_ready", InReady, 0);
        end
        OutReady = 1'b1; InValid = 1'b1;
        @(posedge Clk); #1;
        model_count = (model_count + 1) % 65536;
        OutReady = 1'b0; InValid = 1'b0;
        check("consume_valid", OutValid, 0);
        check("consume_ready", InReady, 1);
        check("op_count", OpCount, model_count);
        stub_en = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        check("rst_in_ready", InReady, 1);
        check("rst_out_valid", OutValid, 0);
        check("rst_out", Out, 0);
        check("rst_flags", OutFlags, 0);
        check("rst_count", OpCount, 0);
        check("rst_alu_a", AluA, 0);
        check("rst_alu_op", AluOp, 0);
        Rst = 1'b0;
        @(posedge Clk); #1;

        // Reset two cycles into a Div: in-flight op is dropped.
        InA = 32'h40800000; InB = 32'h40000000; InOp = 2'b11; InValid = 1'b1;
        @(posedge Clk); #1;
        InValid = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b1;
        #1;
        check("mid_rst_valid", OutValid, 0);
        check("mid_rst_ready", InReady, 1);
        check("mid_rst_out", Out, 0);
        check("mid_rst_count", OpCount, 0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(posedge Clk); #1;

        run_op(32'h3F800000, 32'h40000000, 2'b00, 0, 1'b0, 32'h0);
        check("add_value", Out, 32'h40400000);
        run_op(32'h40000000, 32'h40400000, 2'b10, 0, 1'b0, 32'h0);
        check("mul_value", Out, 32'h40C00000);
        run_op(32'h3F800000, 32'h00000000, 2'b11, 0, 1'b1, 32'h7F800000);
        check("div_inf_flags", OutFlags, 4'b0100);
        run_op(32'h40A00000, 32'h3F800000, 2'b01, 5, 1'b0, 32'h0);
        check("sub_value", Out, 32'h40800000);
        run_op(rand_normal(), rand_normal(), 2'b00, 0, 1'b1, 32'h7FC00000);
        run_op(rand_normal(), rand_normal(), 2'b10, 1, 1'b1, 32'h00000000);
        run_op(rand_normal(), rand_normal(), 2'b01, 0, 1'b1, 32'h80000001);
        run_op(rand_normal(), rand_normal(), 2'b11, 0, 1'b1, 32'hFF800000);
        for (int k = 0; k < 16; k++)
            run_op(rand_normal(), rand_normal(), 2'($urandom), int'($urandom_range(0, 3)), 1'b0, 32'h0);

        // Jump the counter near its top rather than spending ~200k cycles to get there.
        dut.op_count_q = 16'hFFFE;
        model_count = 16'hFFFE;
        for (int k = 0; k < 3; k++)
            run_op(rand_normal(), rand_normal(), 2'b00, 0, 1'b0, 32'h0);
        check("wrap_count", OpCount, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
